// File: rtl/tx_word_serializer.sv
// Word FIFO feeding a byte-at-a-time handshake to an RS232 transmitter.
// Ports: clk, rst (sync, active-high); word_in/word_valid/word_ready push side;
//        TX/start_TX/TX_ready transmitter side; busy, level, overflow status.
module tx_word_serializer #(
    parameter int DEPTH      = 4,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              word_in,
    input  logic                     word_valid,
    output logic                     word_ready,
    output logic [7:0]               TX,
    output logic                     start_TX,
    input  logic                     TX_ready,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT_LOW,
        WAIT_HIGH
    } state_t;

    state_t        state;
    state_t        stateNext;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;

    logic [31:0]   shiftReg;
    logic [31:0]   shiftNext;
    logic [1:0]    byteIdx;
    logic [1:0]    byteIdxNext;
    logic          waitCnt;
    logic          waitCntNext;
    logic [7:0]    txNext;
    logic          startNext;
    logic [7:0]    curByte;

    logic          push;
    logic          pop;

    // Readiness comes from registered occupancy only, so a pop in the
    // same cycle never opens a slot early.
    assign word_ready = (level != FULL_LEVEL);
    assign push       = word_valid && word_ready;
    assign pop        = (state == IDLE) && (level != '0);
    assign busy       = (level != '0) || (state != IDLE);

    assign curByte = BIG_ENDIAN ? shiftReg[31:24] : shiftReg[7:0];

    // Storage is not reset; occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wrPtr] <= word_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (word_valid && !word_ready) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shiftReg <= '0;
            byteIdx  <= '0;
            waitCnt  <= 1'b0;
            TX       <= '0;
            start_TX <= 1'b0;
        end else begin
            state    <= stateNext;
            shiftReg <= shiftNext;
            byteIdx  <= byteIdxNext;
            waitCnt  <= waitCntNext;
            TX       <= txNext;
            start_TX <= startNext;
        end
    end

    always_comb begin
        stateNext   = state;
        shiftNext   = shiftReg;
        byteIdxNext = byteIdx;
        waitCntNext = waitCnt;
        txNext      = TX;
        startNext   = 1'b0;
        case (state)
            IDLE: begin
                if (pop) begin
                    shiftNext   = mem[rdPtr];
                    byteIdxNext = 2'd0;
                    stateNext   = LOAD;
                end
            end
            LOAD: begin
                txNext    = curByte;
                stateNext = SEND;
            end
            SEND: begin
                if (TX_ready) begin
                    startNext   = 1'b1;
                    waitCntNext = 1'b0;
                    stateNext   = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                // A transmitter that finishes instantly never drops
                // TX_ready, so give up waiting after two cycles.
                if (!TX_ready || waitCnt) begin
                    stateNext = WAIT_HIGH;
                end else begin
                    waitCntNext = 1'b1;
                end
            end
            WAIT_HIGH: begin
                if (TX_ready) begin
                    if (byteIdx == 2'd3) begin
                        stateNext = IDLE;
                    end else begin
                        byteIdxNext = byteIdx + 2'd1;
                        shiftNext   = BIG_ENDIAN ?
                                      {shiftReg[23:0], 8'h00} :
                                      {8'h00, shiftReg[31:8]};
                        stateNext   = LOAD;
                    end
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_tx_word_serializer.sv
// Self-checking bench for tx_word_serializer: big- and little-endian
// instances in lockstep, a transmitter model, and a byte-stream reference.
module tb_tx_word_serializer;

    localparam int SLOW = 0;
    localparam int HOLD = 1;
    localparam int FAST = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] word_in = '0;
    logic        word_valid = 1'b0;
    logic        TX_ready = 1'b0;

    logic        word_ready0, start0, busy0, ovf0;
    logic [7:0]  tx0;
    logic [2:0]  level0;
    logic        word_ready1, start1, busy1, ovf1;
    logic [7:0]  tx1;
    logic [2:0]  level1;

    int          passCnt = 0;
    int          failCnt = 0;
    int          totalCnt = 0;
    int          cyc = 0;
    int          txMode = SLOW;
    int          busyCnt = 0;
    int          consecViol = 0;
    int          stepMis = 0;
    logic        prevStart = 1'b0;

    logic [7:0]  capQ0[$];
    logic [7:0]  capQ1[$];
    int          capCyc[$];
    logic [7:0]  expBE[$];
    logic [7:0]  expLE[$];

    tx_word_serializer #(.DEPTH(4), .BIG_ENDIAN(1'b1)) dut0 (
        .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid),
        .word_ready(word_ready0), .TX(tx0), .start_TX(start0),
        .TX_ready(TX_ready), .busy(busy0), .level(level0), .overflow(ovf0)
    );

    tx_word_serializer #(.DEPTH(4), .BIG_ENDIAN(1'b0)) dut1 (
        .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid),
        .word_ready(word_ready1), .TX(tx1), .start_TX(start1),
        .TX_ready(TX_ready), .busy(busy1), .level(level1), .overflow(ovf1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter: SLOW goes not-ready for 10 cycles after each request,
    // HOLD never becomes ready, FAST is always ready.
    always @(posedge clk) begin
        case (txMode)
            HOLD: begin
                TX_ready <= 1'b0;
                busyCnt  <= 0;
            end
            FAST: begin
                TX_ready <= 1'b1;
            end
            default: begin
                if (start0) begin
                    busyCnt  <= 10;
                    TX_ready <= 1'b0;
                end else if (busyCnt > 0) begin
                    busyCnt  <= busyCnt - 1;
                    TX_ready <= (busyCnt == 1);
                end else begin
                    TX_ready <= 1'b1;
                end
            end
        endcase
    end

    always @(negedge clk) begin
        if (start0) begin
            capQ0.push_back(tx0);
            capQ1.push_back(tx1);
            capCyc.push_back(cyc);
        end
        if (start0 && prevStart) consecViol++;
        if ((start0 !== start1) || (level0 !== level1) || (busy0 !== busy1))
            stepMis++;
        prevStart = start0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else begin
            failCnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void addWord(input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            expBE.push_back(8'((w >> (24 - 8 * k)) & 32'hFF));
            expLE.push_back(8'((w >> (8 * k)) & 32'hFF));
        end
    endfunction

    task automatic clearQueues();
        capQ0.delete();
        capQ1.delete();
        capCyc.delete();
        expBE.delete();
        expLE.delete();
    endtask

    task automatic compareBytes(input string tag);
        int n;
        chk({tag, "_count"}, 64'(capQ0.size()), 64'(expBE.size()));
        n = (capQ0.size() < expBE.size()) ? capQ0.size() : expBE.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_be%0d", tag, i), 64'(capQ0[i]), 64'(expBE[i]));
            chk($sformatf("%s_le%0d", tag, i), 64'(capQ1[i]), 64'(expLE[i]));
        end
    endtask

    task automatic waitIdle(input int limit, input string tag);
        int n = 0;
        while (busy0 !== 1'b0 && n < limit) begin
            tick();
            n++;
        end
        chk({tag, "_idle"}, 64'(n < limit), 64'(1));
        repeat (3) tick();
    endtask

    task automatic doReset();
        rst = 1'b1;
        word_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic streamWords(input int count);
        logic [31:0] w;
        int n;
        for (int i = 0; i < count; i++) begin
            w = $urandom;
            word_in = w;
            word_valid = 1'b1;
            n = 0;
            while (!word_ready0 && n < 2000) begin
                tick();
                n++;
            end
            if (n >= 2000) chk("ready_timeout", 64'(n), 64'(0));
            tick();
            addWord(w);
        end
        word_valid = 1'b0;
    endtask

    initial begin
        int pushCyc;
        int n;
        int minGap;

        doReset();
        chk("rst_word_ready", 64'(word_ready0), 64'(1));
        chk("rst_busy", 64'(busy0), 64'(0));
        chk("rst_level", 64'(level0), 64'(0));
        chk("rst_overflow", 64'(ovf0), 64'(0));
        chk("rst_start", 64'(start0), 64'(0));
        chk("rst_tx", 64'(tx0), 64'(0));

        // Single word, slow transmitter.
        clearQueues();
        word_in = 32'hDEADBEEF;
        word_valid = 1'b1;
        tick();
        pushCyc = cyc;
        word_valid = 1'b0;
        addWord(32'hDEADBEEF);
        chk("push_level", 64'(level0), 64'(1));
        chk("push_busy", 64'(busy0), 64'(1));
        waitIdle(300, "single");
        compareBytes("single");
        if (capCyc.size() > 0)
            chk("latency", 64'(capCyc[0] - pushCyc), 64'(3));
        chk("single_busy", 64'(busy0), 64'(0));

        // Full FIFO and overflow with the transmitter stalled.
        doReset();
        clearQueues();
        txMode = HOLD;
        tick();
        word_valid = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            word_in = 32'(i);
            if (i <= 5) addWord(32'(i));
            if (i == 6) begin
                chk("full_level", 64'(level0), 64'(4));
                chk("full_ready", 64'(word_ready0), 64'(0));
                chk("full_ovf_pre", 64'(ovf0), 64'(0));
            end
            tick();
        end
        word_valid = 1'b0;
        chk("ovf_level", 64'(level0), 64'(4));
        chk("ovf_set", 64'(ovf0), 64'(1));
        chk("ovf_no_start", 64'(capQ0.size()), 64'(0));
        txMode = SLOW;
        waitIdle(2000, "drain");
        compareBytes("drain");
        chk("ovf_sticky", 64'(ovf0), 64'(1));

        // Reset in the middle of a word; word_valid is ignored under reset.
        clearQueues();
        word_in = 32'h11223344;
        word_valid = 1'b1;
        tick();
        word_valid = 1'b0;
        n = 0;
        while (capQ0.size() < 2 && n < 500) begin
            tick();
            n++;
        end
        chk("mid_two_bytes", 64'(capQ0.size()), 64'(2));
        rst = 1'b1;
        word_valid = 1'b1;
        word_in = 32'hFFFFFFFF;
        tick();
        rst = 1'b0;
        word_valid = 1'b0;
        chk("mid_level", 64'(level0), 64'(0));
        chk("mid_ovf", 64'(ovf0), 64'(0));
        chk("mid_tx", 64'(tx0), 64'(0));
        chk("mid_busy", 64'(busy0), 64'(0));
        repeat (40) tick();
        chk("mid_no_more", 64'(capQ0.size()), 64'(2));
        clearQueues();
        word_in = 32'hA5A5A5A5;
        word_valid = 1'b1;
        tick();
        word_valid = 1'b0;
        addWord(32'hA5A5A5A5);
        waitIdle(300, "after_rst");
        compareBytes("after_rst");

        // Random stream, slow transmitter, pointers wrap repeatedly.
        doReset();
        clearQueues();
        streamWords(12);
        waitIdle(3000, "stream");
        compareBytes("stream");

        // Random words, transmitter that never drops ready.
        doReset();
        clearQueues();
        txMode = FAST;
        repeat (2) tick();
        streamWords(3);
        waitIdle(500, "fast");
        compareBytes("fast");
        minGap = 1000;
        for (int i = 1; i < capCyc.size(); i++)
            if (capCyc[i] - capCyc[i-1] < minGap)
                minGap = capCyc[i] - capCyc[i-1];
        chk("fast_gap", 64'(minGap >= 5), 64'(1));

        chk("no_consec_start", 64'(consecViol), 64'(0));
        chk("lockstep", 64'(stepMis), 64'(0));

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
